seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle restoring divider that inverts the 8x8 multiplier. It divides a 16-bit unsigned dividend by an 8-bit unsigned divisor and returns a 16-bit quotient and an 8-bit remainder, producing one quotient bit per clock. It sits beside the multiplier, so any 16-bit product can be divided back by one of its 8-bit factors. A start/busy/done handshake connects it to the surrounding control logic.

## Interface
- Parameters: none. Widths are fixed at a 16-bit dividend and an 8-bit divisor, matching the multiplier product and operand widths.
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only when busy=0
- dividend  input  16  unsigned dividend; captured on an accepted start
- divisor  input  8  unsigned divisor; captured on an accepted start
- busy  output  1  high from the cycle after an accepted start through the done cycle inclusive
- done  output  1  one-cycle pulse; results valid in this cycle
- quotient  output  16  unsigned quotient
- remainder  output  8  unsigned remainder
- div_by_zero  output  1  set with done when the captured divisor was 0

## Operation
- Reset is synchronous: reset=1 at a rising edge forces the following.
  - State goes to IDLE.
  - busy, done, quotient, remainder and div_by_zero all go to 0.
  - Reset has priority over start and over any in-flight division. An aborted division produces no done pulse.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:** start=1 captures dividend into shift register Q[15:0], divisor into D[7:0] and clears partial remainder R[8:0].
  - If divisor≠0, go to RUN with iteration counter = 15.
  - If divisor=0, go straight to DONE with quotient=16'hFFFF, remainder=8'h00, div_by_zero=1.
- **RUN:** each cycle performs one iteration.
  - Form T = {R[7:0], Q[15]} (9 bits).
  - If T ≥ {1'b0, D}: R ← T − D and the new quotient bit is 1. Otherwise R ← T and the bit is 0.
  - Q ← {Q[14:0], bit}.
  - The counter decrements. The iteration performed at counter=0 is the last one; it loads the quotient/remainder outputs from Q and R[7:0], and the FSM goes to DONE.
- Invariant: R < D after every iteration, so R[8] is always 0 after a subtract. The remainder output is always R[7:0].
- **DONE:** done=1 for exactly one cycle, then the FSM returns to IDLE.
- quotient, remainder and div_by_zero hold their values until the next accepted start updates them. div_by_zero is cleared on the next accepted start with a nonzero divisor.
- start is ignored while busy=1, including during the DONE cycle.
- start held high continuously begins a new division in the first IDLE cycle.
- Operands may change after capture without affecting the division in flight.

## Timing
- Let E0 be the rising edge at which start=1 is sampled in IDLE.
- Normal division:
  - busy=1 after E0.
  - Iterations occur at edges E1..E16.
  - After E16: done=1, results valid, busy=1.
  - After E17: done=0, busy=0, and the block is back in IDLE.
  - Latency from accepted start to done is 16 cycles. Maximum throughput is one division per 18 cycles.
- Divide by zero:
  - After E0: state DONE, done=1, busy=1, and results already updated.
  - After E1: back in IDLE.
- Reset asserted at any edge En: all outputs are 0 after En. start is not accepted in a cycle where reset=1.
- No combinational path exists from the inputs to any output. All outputs are registered.

## Test plan
- Reset: reset=1 for 2 cycles with random inputs -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Basic and edge values: each check must see done exactly 16 cycles after start, with busy high for 17 cycles.
  - 1000/7 -> quotient=142, remainder=6.
  - 16'hFFFF/8'h01 -> quotient=16'hFFFF, remainder=0.
  - 16'hFFFF/8'hFF -> quotient=257, remainder=0.
  - 100/200 -> quotient=0, remainder=100.
  - 0/5 -> quotient=0, remainder=0.
- Divide by zero: 1234/0 -> done one cycle after start, quotient=16'hFFFF, remainder=0, div_by_zero=1. A following 50/5 -> quotient=10, remainder=0, div_by_zero=0.
- Multiplier round trip: 200*150 = 30000; 30000/150 -> quotient=200, remainder=0. Repeat across 1000 random A,B with B≠0, checking A*B/B = A and remainder=0. Also cover random dividend/divisor pairs against a reference model.
- Handshake abuse:
  - Pulse start again mid-RUN and during the DONE cycle with different operands -> ignored, and the original results are returned.
  - Hold start high continuously -> back-to-back divisions every 18 cycles.
  - Change operands after E0 -> no effect on the division in flight.
- Reset mid-operation: assert reset at E8 of 1000/7 -> no done pulse and outputs 0. Then 81/9 -> quotient=9, remainder=0.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus for the sequential divider
interface seq_divider_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 16/8 restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_divider (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [15:0] q;
  logic [7:0]  d;
  logic [7:0]  r;
  logic [3:0]  cnt;
  logic [8:0]  t;
  logic        qb;
  logic [7:0]  rn;
  // R stays below D, so its top bit is always zero and only 8 bits are stored
  always_comb begin
    t = {r, q[15]};
    qb = t >= {1'b0, d};
    rn = qb ? t[7:0] - d : t[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          q <= bus.dividend;
          d <= bus.divisor;
          r <= '0;
          cnt <= 4'd15;
          bus.busy <= 1'b1;
          if (bus.divisor == 8'd0) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.quotient <= 16'hFFFF;
            bus.remainder <= 8'h00;
            bus.div_by_zero <= 1'b1;
          end else begin
            state <= RUN;
            bus.div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          r <= rn;
          q <= {q[14:0], qb};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.quotient <= {q[14:0], qb};
            bus.remainder <= rn;
          end
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench, random and directed divisions against an arithmetic model
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  seq_divider_if bus ();
  seq_divider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          cyc;
    int          blen;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0, pass = 0, tot = 0, busy_len = 0, last_blen = 0, last_acc = 0;

  function automatic void chk(string n, longint a, longint x);
    tot++;
    if (a == x) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, x);
  endfunction

  // monitor samples just after each rising edge; inputs only move on falling edges
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) busy_len = 0;
    else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          tot++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with no division outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("div_by_zero", bus.div_by_zero, e.z);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", bus.busy, 1);
          last_blen = e.blen;
        end
      end
      if (bus.busy) busy_len++;
      else if (busy_len != 0) begin
        chk("busy_len", busy_len, last_blen);
        busy_len = 0;
      end
    end
  end

  task automatic wait_not_busy();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input logic ez, input bit keep);
    exp_t x;
    wait_not_busy();
    if (bus.busy) begin
      tot++;
      $display("FAIL busy_timeout: busy still 1 before %0d/%0d, expected 0", a, b);
      return;
    end
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    x.q = eq;
    x.r = er;
    x.z = ez;
    x.cyc = cyc + (b == 8'd0 ? 1 : 17);
    x.blen = (b == 8'd0) ? 1 : 17;
    sb.push_back(x);
    last_acc = cyc;
    @(negedge clk);
    if (!keep) bus.start = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor = 8'($urandom);
  endtask

  task automatic div_model(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) do_div(a, b, 16'hFFFF, 8'h00, 1'b1, 1'b0);
    else do_div(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || bus.busy) begin
      tot++;
      $display("FAIL idle_timeout: %0d results outstanding busy=%0d, expected 0 and 0", sb.size(), bus.busy);
    end
  endtask

  task automatic check_zero(string n);
    chk({n, "_busy"}, bus.busy, 0);
    chk({n, "_done"}, bus.done, 0);
    chk({n, "_quotient"}, bus.quotient, 0);
    chk({n, "_remainder"}, bus.remainder, 0);
    chk({n, "_div_by_zero"}, bus.div_by_zero, 0);
  endtask

  initial begin
    int prev, ra, rb;
    bus.start = 1'($urandom);
    bus.dividend = 16'($urandom);
    bus.divisor = 8'($urandom);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    check_zero("reset");

    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0);
    do_div(16'hFFFF, 8'h01, 16'hFFFF, 8'd0, 1'b0, 1'b0);
    do_div(16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 1'b0);
    do_div(16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 1'b0);
    do_div(16'd0, 8'd5, 16'd0, 8'd0, 1'b0, 1'b0);
    do_div(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1'b0);
    do_div(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 1'b0);
    do_div(16'd30000, 8'd150, 16'd200, 8'd0, 1'b0, 1'b0);
    wait_idle();

    // start pulses mid-run and in the done cycle must be ignored
    do_div(16'd5000, 8'd13, 16'd384, 8'd8, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    bus.dividend = 16'd999;
    bus.divisor = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 30 && !bus.done; n++) @(negedge clk);
    chk("reached_done", bus.done, 1);
    bus.dividend = 16'd777;
    bus.divisor = 8'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_ignored_in_done", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("still_idle", bus.busy, 0);
    wait_idle();

    // start held high gives back-to-back divisions every 18 cycles
    do_div(16'd4321, 8'd10, 16'd432, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      prev = last_acc;
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(1, 255);
      do_div(16'(ra), 8'(rb), 16'(ra / rb), 8'(ra % rb), 1'b0, 1'b1);
      chk("hold_spacing", last_acc - prev, 18);
    end
    bus.start = 1'b0;
    wait_idle();

    // reset at E8 aborts without a done pulse
    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check_zero("midreset");
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", bus.done, 0);
    do_div(16'd81, 8'd9, 16'd9, 8'd0, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(1, 255);
      do_div(16'(ra * rb), 8'(rb), 16'(ra), 8'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      rb = (i % 50 == 0) ? 0 : $urandom_range(0, 255);
      div_model(16'($urandom), 8'(rb));
    end
    wait_idle();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
